// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_pkg                                                 |
// | Description : Shared types, key map and helpers for the keypad row       |
// |               decoder: FSM state enum, 4x4 row/column to hex map,        |
// |               one-hot check and lowest-set-bit index.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } key_state_t;

    // Indexed [row][column]; row 3 carries the E 0 F D layout of the pad.
    localparam logic [3:0] c_KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // True only when exactly one bit is set.
    function automatic logic onehot_valid(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [1:0] lowest_set_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_2ff                                                   |
// | Description : Parameterized-width two-flop synchronizer for              |
// |               asynchronous level inputs.                                 |
// | Ports       : clk   - system clock                                       |
// |               reset - synchronous, active-low reset (clears both stages) |
// |               d     - asynchronous input bus                             |
// |               q     - synchronized output (second stage)                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_row_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_row_decoder                                         |
// | Description : Samples the raw keypad rows against the scanner's one-hot  |
// |               column, debounces press/release on scan ticks and emits a  |
// |               hex key code with a one-clock valid pulse.                 |
// | Ports       : clk            - system clock                              |
// |               reset          - synchronous, active-low reset             |
// |               enable         - one-clk scan tick                         |
// |               col_keys[3:0]  - one-hot driven column                     |
// |               rows[3:0]      - raw asynchronous row lines, active-high   |
// |               button_pressed - key detected or being tracked             |
// |               key_code[3:0]  - last accepted key                         |
// |               key_valid      - one-clk pulse on acceptance               |
// |               key_held       - accepted key still down                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module keypad_row_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] col_keys,
    input  logic [3:0] rows,
    output logic       button_pressed,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [CNT_W-1:0] c_TICKS   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic             c_INSTANT = (DEBOUNCE_TICKS <= 1);

    logic [3:0]       w_rows_s;
    key_state_t       r_state;
    key_state_t       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       r_row;
    logic [3:0]       r_col;
    logic [3:0]       w_row_nx;
    logic [3:0]       w_col_nx;
    logic             w_row_any;
    logic             w_col_valid;
    logic [3:0]       w_row_onehot;
    logic             w_row_hit;
    logic             w_col_match;
    logic             w_accept;
    logic             w_release_done;
    logic [3:0]       w_code;
    logic             r_button_pressed;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (w_rows_s)
    );

    assign w_row_any    = |w_rows_s;
    assign w_col_valid  = onehot_valid(col_keys);
    // Lowest row wins when several rows share the active column.
    assign w_row_onehot = 4'b0001 << lowest_set_idx(w_rows_s);
    assign w_row_hit    = |(w_rows_s & r_row);
    assign w_col_match  = (col_keys == r_col);
    // Saturating increment so a long stable period can never wrap.
    assign w_cnt_inc    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
    assign w_code       = c_KEY_MAP[lowest_set_idx(w_row_nx)][lowest_set_idx(w_col_nx)];

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_row_nx       = r_row;
        w_col_nx       = r_col;
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_row_any && w_col_valid) begin
                    w_row_nx = w_row_onehot;
                    w_col_nx = col_keys;
                    w_cnt_nx = c_CNT_ONE;
                    if (c_INSTANT) begin
                        w_accept   = 1'b1;
                        w_state_nx = HELD;
                    end else begin
                        w_state_nx = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                // Abort is evaluated every clk, not only on ticks.
                if (!w_row_hit || !w_col_match) begin
                    w_state_nx = IDLE;
                end else if (enable) begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc >= c_TICKS) begin
                        w_accept   = 1'b1;
                        w_state_nx = HELD;
                    end
                end
            end
            HELD: begin
                // Only the latched row matters here; other keys are ignored.
                if (!w_row_hit) begin
                    w_cnt_nx   = '0;
                    w_state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (w_row_hit) begin
                    w_state_nx = HELD;
                end else if (enable) begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc >= c_TICKS) begin
                        w_release_done = 1'b1;
                        w_state_nx     = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_row            <= '0;
            r_col            <= '0;
            r_button_pressed <= 1'b0;
            r_key_code       <= 4'h0;
            r_key_valid      <= 1'b0;
            r_key_held       <= 1'b0;
        end else begin
            r_state          <= w_state_nx;
            r_cnt            <= w_cnt_nx;
            r_row            <= w_row_nx;
            r_col            <= w_col_nx;
            r_button_pressed <= (w_state_nx != IDLE) || (w_row_any && w_col_valid);
            r_key_valid      <= w_accept;
            if (w_accept) begin
                r_key_code <= w_code;
                r_key_held <= 1'b1;
            end else if (w_release_done) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign button_pressed = r_button_pressed;
    assign key_code       = r_key_code;
    assign key_valid      = r_key_valid;
    assign key_held       = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_row_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_keypad_row_decoder                                      |
// | Description : Self-checking bench for keypad_row_decoder: directed       |
// |               scenarios plus randomized keypad activity, compared every  |
// |               clock against a behavioural model of the decoder.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_keypad_row_decoder;

    localparam int DEBOUNCE_TICKS = 3;
    localparam int CNT_W          = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       enable   = 1'b0;
    logic [3:0] col_keys = 4'd0;
    logic [3:0] rows     = 4'd0;
    logic       button_pressed;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_row_decoder #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .col_keys       (col_keys),
        .rows           (rows),
        .button_pressed (button_pressed),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .key_held       (key_held)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int kv_cnt = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_CONFIRM = 1, P_HELD = 2, P_RELEASE = 3;
    string      KEYS = "123A456B789CE0FD";
    logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0;
    int         m_phase = P_IDLE;
    int         m_ticks = 0;
    int         m_r = 0, m_c = 0;
    int         e_code = 0;
    bit         e_valid = 1'b0, e_held = 1'b0, e_bp = 1'b0;

    function automatic int key_value(input int r, input int c);
        int v;
        v = int'(KEYS.getc(r * 4 + c));
        if (v >= 65) return v - 55;
        return v - 48;
    endfunction

    task automatic model_accept();
        e_valid = 1'b1;
        e_held  = 1'b1;
        e_code  = key_value(m_r, m_c);
        m_phase = P_HELD;
    endtask

    task automatic model_step();
        logic [3:0] rs;
        int  low, ci;
        bit  any, cv;
        if (!reset) begin
            m_s1 = 4'd0; m_s2 = 4'd0; m_phase = P_IDLE; m_ticks = 0;
            e_code = 0; e_valid = 1'b0; e_held = 1'b0; e_bp = 1'b0;
            return;
        end
        rs   = m_s2;
        m_s2 = m_s1;
        m_s1 = rows;
        any  = (rs != 4'd0);
        low  = 0;
        for (int i = 3; i >= 0; i--) if (rs[i]) low = i;
        cv = ($countones(col_keys) == 1);
        ci = 0;
        for (int i = 0; i < 4; i++) if (col_keys[i]) ci = i;
        e_valid = 1'b0;
        case (m_phase)
            P_IDLE: if (enable && any && cv) begin
                m_r = low; m_c = ci; m_ticks = 1;
                if (m_ticks >= DEBOUNCE_TICKS) model_accept();
                else m_phase = P_CONFIRM;
            end
            P_CONFIRM: begin
                if (!rs[m_r] || col_keys != 4'(1 << m_c)) m_phase = P_IDLE;
                else if (enable) begin
                    m_ticks++;
                    if (m_ticks >= DEBOUNCE_TICKS) model_accept();
                end
            end
            P_HELD: if (!rs[m_r]) begin
                m_ticks = 0; m_phase = P_RELEASE;
            end
            default: begin
                if (rs[m_r]) m_phase = P_HELD;
                else if (enable) begin
                    m_ticks++;
                    if (m_ticks >= DEBOUNCE_TICKS) begin
                        e_held = 1'b0; m_phase = P_IDLE;
                    end
                end
            end
        endcase
        e_bp = (m_phase != P_IDLE) || (any && cv);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("button_pressed", int'(button_pressed), int'(e_bp));
            check("key_code", int'(key_code), e_code);
            check("key_valid", int'(key_valid), int'(e_valid));
            check("key_held", int'(key_held), int'(e_held));
            kv_cnt += int'(key_valid);
        end
    end

    // ---------------- stimulus ----------------
    // Enable is a one-clk strobe every 4th clock, driven alongside the inputs.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            enable = (cyc % 4 == 0);
        end
    endtask

    initial begin
        int  base;
        bit  found;

        // 1. reset with all rows high
        reset = 1'b0; rows = 4'b1111; col_keys = 4'b0001;
        step(1);
        chk_on = 1'b1;
        step(2);
        check("rst_bp", int'(button_pressed), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        reset = 1'b1; rows = 4'b0000;
        step(8);
        check("post_rst_bp", int'(button_pressed), 0);

        // 3. glitch shorter than the debounce
        base = kv_cnt;
        col_keys = 4'b0001; rows = 4'b0001;
        step(4);
        rows = 4'b0000;
        step(20);
        check("glitch_pulses", kv_cnt - base, 0);
        check("glitch_code", int'(key_code), 0);
        check("glitch_bp", int'(button_pressed), 0);

        // 2. clean press of key 8
        base = kv_cnt;
        col_keys = 4'b0010; rows = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (button_pressed) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_within_3clk", int'(found), 1);
        step(80);
        check("press8_pulses", kv_cnt - base, 1);
        check("press8_code", int'(key_code), 8);
        check("press8_held", int'(key_held), 1);
        rows = 4'b0000;
        step(24);
        check("release8_held", int'(key_held), 0);
        check("release8_bp", int'(button_pressed), 0);

        // 4. release bounce on key D
        base = kv_cnt;
        col_keys = 4'b1000; rows = 4'b1000;
        step(30);
        for (int k = 0; k < 4; k++) begin
            rows = 4'b0000;
            step(4);
            check("bounce_held", int'(key_held), 1);
            rows = 4'b1000;
            step(4);
        end
        rows = 4'b0000;
        step(24);
        check("bounceD_pulses", kv_cnt - base, 1);
        check("bounceD_code", int'(key_code), 13);
        check("bounceD_held", int'(key_held), 0);

        // 5. two rows in one column, then another column while held
        base = kv_cnt;
        col_keys = 4'b0100; rows = 4'b1010;
        step(30);
        check("multi_code", int'(key_code), 6);
        check("multi_pulses", kv_cnt - base, 1);
        col_keys = 4'b0001; rows = 4'b1010;
        step(30);
        check("other_col_pulses", kv_cnt - base, 1);
        check("other_col_code", int'(key_code), 6);
        rows = 4'b0000;
        step(24);

        // 6. reset during CONFIRM, then a full debounce afterwards
        base = kv_cnt;
        col_keys = 4'b0010; rows = 4'b0001;
        step(3);
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (enable) begin
                step(1);
                break;
            end
        end
        reset = 1'b0;
        step(1);
        check("midrst_bp", int'(button_pressed), 0);
        check("midrst_code", int'(key_code), 0);
        check("midrst_held", int'(key_held), 0);
        reset = 1'b1;
        step(40);
        check("after_rst_pulses", kv_cnt - base, 1);
        check("after_rst_code", int'(key_code), 2);
        rows = 4'b0000;
        step(24);

        // randomized keypad activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) col_keys = 4'($urandom_range(0, 15));
                else col_keys = 4'(1 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 2) == 0) rows = 4'd0;
                else rows = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            else reset = 1'b1;
            step(1);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_row_decoder.md
Name: keypad_row_decoder

Overview:
Receive-side partner of the keypad column scanner. The scanner drives one-hot columns; this block samples the raw keypad row lines and reports key activity back to it.
- Generates button_pressed so the scanner freezes on the active column.
- Debounces press and release on scan-enable ticks.
- Decodes (row, column) into a 4-bit hex key code with a single-cycle valid pulse for the display/key-history logic.

Parameters:
DEBOUNCE_TICKS, 4, number of enable ticks a press or release must stay stable before it is accepted (must be 1 or more).
CNT_W, 4, width of the debounce counter (must satisfy 2^CNT_W > DEBOUNCE_TICKS).

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-low reset.
enable  input  1  scan tick from the clock divider, one clk wide; the same strobe the scanner uses.
col_keys  input  4  one-hot column currently driven by the scanner (bit0 = column 0).
rows  input  4  raw asynchronous keypad row lines, active-high (bit0 = row 0).
button_pressed  output  1  to scanner: a key is detected or being tracked.
key_code  output  4  hex value of the last accepted key.
key_valid  output  1  one-clk pulse when a new key is accepted.
key_held  output  1  high while an accepted key remains pressed.

Behaviour:
Clock and reset
- One clock, clk. Reset is synchronous and active-low, port named reset.
- With reset low at a clk edge: state=IDLE, counter=0, latched row/column=0, synchronizer flops=0, button_pressed=0, key_code=0, key_valid=0, key_held=0.
- Reset mid-operation aborts any press with no key_valid pulse.

Input synchronizer
- rows passes through a 2-flop synchronizer; rows_s is the second stage.
- All decisions use rows_s only. Minimum latency from rows to any reaction is 2 clk.

Row selection
- row_any = |rows_s.
- The selected row is the lowest-index set bit of rows_s.
- A column is valid only when col_keys is exactly one-hot.

button_pressed (registered)
- Next value = (next state != IDLE) OR (row_any AND column valid).

State machine (counter advances only on clk edges where enable=1)
- IDLE:
  - On enable with row_any and a valid column: latch row and column, counter=1, go to CONFIRM.
  - If DEBOUNCE_TICKS=1, go straight to HELD with the accept action.
  - A non-one-hot column is ignored.
- CONFIRM:
  - If the latched row bit in rows_s drops, or col_keys differs from the latched column: return to IDLE with no pulse. Checked on any clk.
  - Otherwise, on each enable, counter+1. When counter reaches DEBOUNCE_TICKS, perform the accept action and go to HELD.
- Accept action: key_code <= map(row, col); key_valid=1 for exactly one clk; key_held=1.
- HELD:
  - While the latched row is high, stay.
  - When it goes low: counter=0, go to RELEASE.
  - Other keys pressed meanwhile are ignored; no rollover.
- RELEASE:
  - On each enable with the latched row low, counter+1. When counter reaches DEBOUNCE_TICKS: key_held=0, go to IDLE.
  - If the latched row reasserts before that: back to HELD, no new pulse (bounce).
- The counter saturates and never wraps.

Key map, by row r / col c
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: E 0 F D

Boundary conditions
- Two rows high in the same column: the lowest row wins.
- A key in another column while HELD: ignored.
- key_code holds its last value until the next accept.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (IDLE, CONFIRM, HELD, RELEASE);
  - the 4x4 key-map constant array;
  - a function onehot_valid().
- One sub-module, sync_2ff: a parameterized-width 2-flop synchronizer with synchronous active-low reset.
- The FSM, counter and decode logic stay in keypad_row_decoder.

Test Plan:
Use DEBOUNCE_TICKS=3 and enable every 4th clk for all scenarios.
1. Reset low for 3 clk with rows=4'b1111 -> all outputs 0, state IDLE. Release reset with rows=0 -> outputs stay 0.
2. Clean press: col_keys=0010, rows=0100 held for 20 enables, then 0000 -> button_pressed=1 within 3 clk. Exactly one key_valid pulse at the 3rd enable after detection, key_code=8. key_held=1 until the 3rd enable after release, then button_pressed=0.
3. Glitch: col_keys=0001, rows=0001 for only 1 enable, then 0 -> return to IDLE, no key_valid, key_code unchanged (0).
4. Release bounce: press col 3, row 3 (key D). After acceptance toggle the row low/high within 2 enables several times, then release -> single key_valid, key_code=D, key_held stays 1 through the bounce.
5. Multi-key: col_keys=0100, rows=1010 -> key_code=6 (row 1 wins). A later rows=1000 press in col 0 during HELD -> ignored, no pulse.
6. Reset mid-CONFIRM: assert reset after the 1st enable of a press -> all outputs 0 next clk. After deassert with the key still held -> normal acceptance with a full 3-tick debounce.
